timer_bank: RTL and testbench
=============================

# timer_bank

Multi-channel memory-mapped timer for the processor I/O bus, the successor to the single-channel timer device. It provides NCH independent down-counters, each with its own reload, prescaler, one-shot/periodic mode, run enable and interrupt enable. A shared status register allows one-access polling and clearing of all channels. It sits on ABUS/RBUS/WBUS alongside memory and the other bus devices, and drives one OR-combined INTR line to the interrupt controller.

## Interface

- ABITS, 32: ABUS width.
- DBITS, 32: RBUS/WBUS width, must be ≥ max(CBITS, NCH, 5).
- RBASE, 32'hF0000100: byte address of channel 0 CNT.
- NCH, 4: channel count, 1..16.
- CBITS, 16: counter/reload width.
- DIVN, 1000: prescaler terminal value; one count tick per DIVN+1 clocks.
- DIVB, 10: prescaler width, must hold DIVN.
- CLK  in  1  clock; all state changes on posedge.
- INIT  in  1  reset, synchronous, active-high.
- LOCK  in  1  clock-valid qualifier; when 0, no state (including INIT) changes.
- ABUS  in  ABITS  bus address.
- RE  in  1  read enable.
- WE  in  1  write enable.
- WBUS  in  DBITS  write data.
- RBUS  inout  DBITS  read data; driven only on a selected read, else high-Z.
- INTR  out  1  OR over channels of (Rdy & IE).

## Operation

- Register map, channel c at RBASE + 8*c: +0 CNT (r/w), +2 RES (r/w), +4 CTL (r/w). STAT at RBASE + 8*NCH. All other addresses are unselected.
- Reads zero-extend to DBITS.
- CTL bits:
  - [0] Rdy: write 0 clears, write 1 is ignored.
  - [1] Ovr: write 0 clears, write 1 is ignored.
  - [2] ONESHOT.
  - [3] EN.
  - [4] IE.
  - Bits [DBITS-1:5] read 0.
- STAT read: bits [NCH-1:0] = Rdy of each channel, upper bits 0. STAT write: every 1 bit clears that channel's Rdy (write-1-to-clear). Ovr is unaffected.
- Write CNT: CNT <= WBUS[CBITS-1:0], TDIV <= 0.
- Write RES: RES <= WBUS. If CNT == 0, also CNT <= WBUS and TDIV <= 0.
- A channel counts only when EN=1 and CNT != 0. Each counting cycle:
  - If TDIV != DIVN: TDIV++.
  - Otherwise TDIV <= 0 and a tick occurs.
- On a tick:
  - If CNT != 1: CNT <= CNT-1.
  - If CNT == 1 (expiry): Rdy <= 1; Ovr <= 1 if Rdy was already 1.
    - Periodic: CNT <= RES. If RES == 0 the channel stops at 0.
    - ONESHOT: CNT <= 0 and EN <= 0.
- EN=0 freezes both CNT and TDIV. Re-setting EN resumes from the frozen TDIV.
- Simultaneous events, same channel, same edge:
  - Expiry vs. Rdy clear (CTL or STAT write): expiry wins, Rdy stays 1. Ovr is set only if Rdy was 1 before the edge.
  - Expiry vs. CNT write: the write wins, no Rdy/Ovr change, TDIV <= 0.
  - Expiry vs. RES write: the new RES is latched, and the reload uses the new value.
  - Expiry vs. CTL write: the CTL write's EN/ONESHOT/IE take effect; the expiry's Rdy/Ovr rules still apply.
- Channels are fully independent. A write selects at most one register.
- INIT (with LOCK=1) resets every CNT, RES, TDIV, Rdy, Ovr, ONESHOT, EN and IE to 0. This aborts any countdown in progress.
- Reset outputs: INTR=0, RBUS high-Z.

## Timing

- Reads are combinational: RBUS is valid in the same cycle that RE and the address are valid. There is no read side effect.
- Writes take effect at the posedge where WE=1.
- INTR is a registered-state function and updates on the edge that changes Rdy or IE.
- Latency: CNT=N written (EN=1) at edge 0 → Rdy=1 after edge N*(DIVN+1).
- Periodic expiries repeat every RES*(DIVN+1) cycles.
- A CNT read returns the pre-edge value. Counting never pauses for bus accesses except writes to that channel's CNT or RES.

## Test plan

All scenarios use NCH=4 and DIVN=3.

- INIT for 1 cycle → all registers read 0, STAT=0, INTR=0, RBUS high-Z with RE=0.
- Ch0: RES=5, CTL=0x18 (EN, IE), CNT=5 → Rdy and INTR rise after edge 20. CNT reloads to 5, and the second expiry at edge 40 sets Ovr=1.
- Ch1: ONESHOT, EN, CNT=2 → Rdy after edge 8. CNT stays 0, EN reads 0, and no further expiries occur over 100 cycles.
- Ch2 and ch3 expire, then STAT is written with 0x4 → only ch2's Rdy clears, STAT reads 0x8, INTR follows ch3 IE.
- A CTL write clearing Rdy lands on ch0's expiry edge → Rdy stays 1. An independent run with a CNT=7 write on the expiry edge → CNT=7, Rdy unchanged.
- EN cleared mid-count at CNT=3, held 10 cycles, then re-enabled → CNT stays 3 while disabled, and expiry is delayed by exactly 10 cycles. INIT asserted mid-count → CNT=0 and no Rdy afterwards.

Source files
------------

// File: rtl/timer_bank.sv
// Multi-channel memory-mapped down-counter timer bank on the ABUS/RBUS/WBUS I/O bus.
// Each channel has its own reload value, prescaler, mode, enable and interrupt enable.
module timer_bank #(
    parameter int unsigned ABITS = 32,
    parameter int unsigned DBITS = 32,
    parameter logic [31:0] RBASE = 32'hF0000100,
    parameter int unsigned NCH   = 4,
    parameter int unsigned CBITS = 16,
    parameter int unsigned DIVN  = 1000,
    parameter int unsigned DIVB  = 10
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             LOCK,
    input  logic [ABITS-1:0] ABUS,
    input  logic             RE,
    input  logic             WE,
    input  logic [DBITS-1:0] WBUS,
    inout  wire logic [DBITS-1:0] RBUS,
    output logic             INTR
);

    logic [CBITS-1:0] cnt   [NCH];
    logic [CBITS-1:0] res   [NCH];
    logic [DIVB-1:0]  tdiv  [NCH];
    logic [CBITS-1:0] cnt_n [NCH];
    logic [CBITS-1:0] res_n [NCH];
    logic [DIVB-1:0]  tdiv_n[NCH];
    logic [NCH-1:0]   rdy, ovr, oneshot, en, ie;
    logic [NCH-1:0]   rdy_n, ovr_n, oneshot_n, en_n, ie_n;

    logic [DBITS-1:0] rdata;
    logic             rsel;
    logic             unused_wbus;

    assign unused_wbus = ^WBUS;

    function automatic logic [ABITS-1:0] addr_of(input int unsigned off);
        return ABITS'(RBASE) + ABITS'(off);
    endfunction

    // Read mux: combinational, no side effects.
    always_comb begin
        rsel  = 1'b0;
        rdata = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (ABUS == addr_of(8*c)) begin
                rsel  = 1'b1;
                rdata = DBITS'(cnt[c]);
            end
            if (ABUS == addr_of(8*c + 2)) begin
                rsel  = 1'b1;
                rdata = DBITS'(res[c]);
            end
            if (ABUS == addr_of(8*c + 4)) begin
                rsel  = 1'b1;
                rdata = DBITS'({ie[c], en[c], oneshot[c], ovr[c], rdy[c]});
            end
        end
        if (ABUS == addr_of(8*NCH)) begin
            rsel  = 1'b1;
            rdata = DBITS'(rdy);
        end
    end

    assign RBUS = (RE && rsel) ? rdata : 'z;
    assign INTR = |(rdy & ie);

    always_comb begin
        cnt_n     = cnt;
        res_n     = res;
        tdiv_n    = tdiv;
        rdy_n     = rdy;
        ovr_n     = ovr;
        oneshot_n = oneshot;
        en_n      = en;
        ie_n      = ie;
        for (int unsigned c = 0; c < NCH; c++) begin
            logic             wr_cnt, wr_res, wr_ctl, wr_stat;
            logic             counting, tick, expire;
            logic [CBITS-1:0] res_new;
            wr_cnt   = WE && (ABUS == addr_of(8*c));
            wr_res   = WE && (ABUS == addr_of(8*c + 2));
            wr_ctl   = WE && (ABUS == addr_of(8*c + 4));
            wr_stat  = WE && (ABUS == addr_of(8*NCH));
            res_new  = wr_res ? WBUS[CBITS-1:0] : res[c];
            counting = en[c] && (cnt[c] != '0);
            tick     = counting && (tdiv[c] == DIVB'(DIVN));
            // A CNT write on the expiry edge cancels the expiry entirely.
            expire   = tick && (cnt[c] == CBITS'(1)) && !wr_cnt;

            if (counting) begin
                tdiv_n[c] = tick ? '0 : tdiv[c] + 1'b1;
                if (tick && cnt[c] != CBITS'(1))
                    cnt_n[c] = cnt[c] - 1'b1;
            end
            if (expire) begin
                if (oneshot[c]) begin
                    cnt_n[c] = '0;
                    en_n[c]  = 1'b0;
                end else begin
                    cnt_n[c] = res_new;
                end
            end

            res_n[c] = res_new;
            if (wr_res && cnt[c] == '0) begin
                cnt_n[c]  = res_new;
                tdiv_n[c] = '0;
            end
            if (wr_ctl) begin
                if (!WBUS[0]) rdy_n[c] = 1'b0;
                if (!WBUS[1]) ovr_n[c] = 1'b0;
                oneshot_n[c] = WBUS[2];
                en_n[c]      = WBUS[3];
                ie_n[c]      = WBUS[4];
            end
            if (wr_stat && WBUS[c])
                rdy_n[c] = 1'b0;
            if (wr_cnt) begin
                cnt_n[c]  = WBUS[CBITS-1:0];
                tdiv_n[c] = '0;
            end
            // Expiry beats any same-edge Rdy clear; Ovr judged on pre-edge Rdy.
            if (expire) begin
                rdy_n[c] = 1'b1;
                if (rdy[c]) ovr_n[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (LOCK) begin
            if (INIT) begin
                cnt     <= '{default: '0};
                res     <= '{default: '0};
                tdiv    <= '{default: '0};
                rdy     <= '0;
                ovr     <= '0;
                oneshot <= '0;
                en      <= '0;
                ie      <= '0;
            end else begin
                cnt     <= cnt_n;
                res     <= res_n;
                tdiv    <= tdiv_n;
                rdy     <= rdy_n;
                ovr     <= ovr_n;
                oneshot <= oneshot_n;
                en      <= en_n;
                ie      <= ie_n;
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank with NCH=4, DIVN=3 (one tick per 4 clocks).
// Inputs change and outputs are sampled just after each negedge.
module tb_timer_bank;

    localparam logic [31:0] B = 32'hF000_0100;

    logic        CLK = 1'b0;
    logic        INIT, LOCK, RE, WE, INTR;
    logic [31:0] ABUS, WBUS;
    wire  [31:0] RBUS;
    logic        drv_en;
    logic [31:0] drv_val;
    int          errors = 0;
    int          checks = 0;

    // Bench-side bus holder used to detect the DUT releasing RBUS.
    assign RBUS = drv_en ? drv_val : 'z;

    always #5 CLK = ~CLK;

    timer_bank #(.NCH(4), .DIVN(3)) dut (
        .CLK (CLK),
        .INIT(INIT),
        .LOCK(LOCK),
        .ABUS(ABUS),
        .RE  (RE),
        .WE  (WE),
        .WBUS(WBUS),
        .RBUS(RBUS),
        .INTR(INTR)
    );

    function automatic logic [31:0] a_cnt(input int c); return B + 32'(8*c);     endfunction
    function automatic logic [31:0] a_res(input int c); return B + 32'(8*c + 2); endfunction
    function automatic logic [31:0] a_ctl(input int c); return B + 32'(8*c + 4); endfunction
    function automatic logic [31:0] a_stat();           return B + 32'h20;        endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ABUS = a; WBUS = d; WE = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        ABUS = a; RE = 1'b1;
        #1 v = RBUS;
        RE = 1'b0;
        chk(tag, v, exp);
    endtask

    // Holds RBUS at 0 from the bench; any DUT drive of a nonzero register shows through.
    task automatic chk_float(input string tag, input logic [31:0] a, input logic re);
        logic [31:0] v;
        drv_val = '0; drv_en = 1'b1;
        ABUS = a; RE = re;
        #1 v = RBUS;
        RE = 1'b0; drv_en = 1'b0;
        chk(tag, v, 32'h0);
    endtask

    initial begin
        INIT = 1'b1; LOCK = 1'b1; RE = 1'b0; WE = 1'b0;
        ABUS = '0; WBUS = '0; drv_en = 1'b0; drv_val = '0;
        @(negedge CLK);
        INIT = 1'b0;

        chk_rd("rst_cnt0", a_cnt(0), 32'h0);
        chk_rd("rst_res1", a_res(1), 32'h0);
        chk_rd("rst_ctl2", a_ctl(2), 32'h0);
        chk_rd("rst_stat", a_stat(), 32'h0);
        chk("rst_intr", {31'b0, INTR}, 32'h0);

        // Ch0 periodic: RES=5, EN|IE, CNT=5 at edge 0 -> expiries at 20 and 40.
        wr(a_res(0), 32'd5);
        wr(a_ctl(0), 32'h18);
        wr(a_cnt(0), 32'd5);
        chk_rd("c0_cnt_e0", a_cnt(0), 32'd5);
        repeat (19) @(negedge CLK);
        chk_rd("c0_cnt_e19", a_cnt(0), 32'd1);
        chk_rd("c0_ctl_e19", a_ctl(0), 32'h18);
        chk("c0_intr_e19", {31'b0, INTR}, 32'h0);
        chk_float("float_re0", a_cnt(0), 1'b0);
        chk_float("float_unsel", B + 32'h1, 1'b1);
        @(negedge CLK);
        chk_rd("c0_ctl_e20", a_ctl(0), 32'h19);
        chk_rd("c0_cnt_e20", a_cnt(0), 32'd5);
        chk("c0_intr_e20", {31'b0, INTR}, 32'h1);
        repeat (20) @(negedge CLK);
        chk_rd("c0_ctl_e40", a_ctl(0), 32'h1B);
        wr(a_ctl(0), 32'h00);
        chk("c0_intr_off", {31'b0, INTR}, 32'h0);

        // Ch1 one-shot: CNT=2 -> expiry at edge 8, then idle.
        wr(a_ctl(1), 32'h0C);
        wr(a_cnt(1), 32'd2);
        repeat (7) @(negedge CLK);
        chk_rd("c1_ctl_e7", a_ctl(1), 32'h0C);
        @(negedge CLK);
        chk_rd("c1_ctl_e8", a_ctl(1), 32'h05);
        chk_rd("c1_cnt_e8", a_cnt(1), 32'h0);
        repeat (100) @(negedge CLK);
        chk_rd("c1_ctl_late", a_ctl(1), 32'h05);
        chk_rd("c1_cnt_late", a_cnt(1), 32'h0);
        wr(a_stat(), 32'h2);
        chk_rd("stat_clr1", a_stat(), 32'h0);

        // Ch2/ch3 expire, then write-1-to-clear only ch2.
        wr(a_ctl(2), 32'h18);
        wr(a_ctl(3), 32'h18);
        wr(a_cnt(2), 32'd1);
        wr(a_cnt(3), 32'd1);
        repeat (4) @(negedge CLK);
        chk_rd("stat_23", a_stat(), 32'hC);
        wr(a_stat(), 32'h4);
        chk_rd("stat_3", a_stat(), 32'h8);
        chk("intr_c3", {31'b0, INTR}, 32'h1);
        wr(a_ctl(3), 32'h09);
        chk("intr_c3_ie0", {31'b0, INTR}, 32'h0);
        chk_rd("stat_3_kept", a_stat(), 32'h8);
        wr(a_ctl(3), 32'h19);
        chk("intr_c3_ie1", {31'b0, INTR}, 32'h1);
        wr(a_stat(), 32'hF);
        chk_rd("stat_allclr", a_stat(), 32'h0);

        // CTL Rdy-clear on the expiry edge: expiry wins.
        wr(a_cnt(0), 32'd0);
        wr(a_ctl(0), 32'h18);
        wr(a_cnt(0), 32'd2);
        repeat (7) @(negedge CLK);
        wr(a_ctl(0), 32'h18);
        chk_rd("race_ctl_ctl", a_ctl(0), 32'h19);
        chk_rd("race_ctl_cnt", a_cnt(0), 32'd5);

        // CNT write on the expiry edge: write wins, no Rdy.
        wr(a_cnt(0), 32'd0);
        wr(a_ctl(0), 32'h18);
        chk_rd("race_cnt_pre", a_ctl(0), 32'h18);
        wr(a_cnt(0), 32'd2);
        repeat (7) @(negedge CLK);
        wr(a_cnt(0), 32'd7);
        chk_rd("race_cnt_cnt", a_cnt(0), 32'd7);
        chk_rd("race_cnt_ctl", a_ctl(0), 32'h18);
        repeat (4) @(negedge CLK);
        chk_rd("race_cnt_tick", a_cnt(0), 32'd6);

        // EN pause for 10 cycles at CNT=3: expiry moves from edge 20 to 30.
        wr(a_cnt(0), 32'd0);
        wr(a_ctl(0), 32'h18);
        wr(a_cnt(0), 32'd5);
        repeat (8) @(negedge CLK);
        chk_rd("pause_cnt_e8", a_cnt(0), 32'd3);
        wr(a_ctl(0), 32'h10);
        chk_rd("pause_cnt_e9", a_cnt(0), 32'd3);
        repeat (9) @(negedge CLK);
        chk_rd("pause_cnt_e18", a_cnt(0), 32'd3);
        chk_rd("pause_ctl_e18", a_ctl(0), 32'h10);
        wr(a_ctl(0), 32'h18);
        repeat (10) @(negedge CLK);
        chk_rd("pause_ctl_e29", a_ctl(0), 32'h18);
        chk_rd("pause_cnt_e29", a_cnt(0), 32'd1);
        @(negedge CLK);
        chk_rd("pause_ctl_e30", a_ctl(0), 32'h19);
        chk_rd("pause_cnt_e30", a_cnt(0), 32'd5);
        chk("pause_intr", {31'b0, INTR}, 32'h1);

        // LOCK=0 freezes everything, including INIT.
        LOCK = 1'b0; INIT = 1'b1;
        repeat (3) @(negedge CLK);
        chk_rd("lock_cnt", a_cnt(0), 32'd5);
        chk_rd("lock_ctl", a_ctl(0), 32'h19);

        // INIT mid-count aborts the countdown.
        LOCK = 1'b1;
        @(negedge CLK);
        INIT = 1'b0;
        chk_rd("init_cnt0", a_cnt(0), 32'h0);
        chk_rd("init_res0", a_res(0), 32'h0);
        chk_rd("init_ctl0", a_ctl(0), 32'h0);
        chk("init_intr", {31'b0, INTR}, 32'h0);
        repeat (40) @(negedge CLK);
        chk_rd("init_stat_late", a_stat(), 32'h0);
        chk_rd("init_cnt_late", a_cnt(0), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
